// File: rtl/fir_tap_load_sequencer.sv
// Coefficient RAM and tap-load sequencer for the two-stage decimation FIR chain.
// Streams stage A then stage B taps from one host-writable RAM and gates the sample path until loaded.
module fir_tap_load_sequencer #(
  parameter int unsigned G_DWIDTH     = 24,
  parameter int unsigned G_TAP_WIDTH  = 16,
  parameter int unsigned G_NUM_TAPS_A = 63,
  parameter int unsigned G_NUM_TAPS_B = 31,
  parameter int unsigned G_ADDR_WIDTH = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    reload,
  input  logic                    cfg_wr_en,
  input  logic [G_ADDR_WIDTH-1:0] cfg_wr_addr,
  input  logic [G_TAP_WIDTH-1:0]  cfg_wr_data,
  output logic                    cfg_wr_err,
  output logic                    fir_enable,
  output logic [G_TAP_WIDTH-1:0]  tap_a_din,
  output logic                    tap_a_din_valid,
  output logic [G_TAP_WIDTH-1:0]  tap_b_din,
  output logic                    tap_b_din_valid,
  output logic                    busy,
  output logic                    load_done,
  input  logic [G_DWIDTH-1:0]     din,
  input  logic                    din_valid,
  output logic                    din_ready,
  output logic [G_DWIDTH-1:0]     dout,
  output logic                    dout_valid,
  input  logic                    dout_ready
);

  typedef enum logic [2:0] {
    DISABLED,
    CLEAR,
    LOAD_A,
    LOAD_B,
    DRAIN,
    RUN
  } state_t;

  localparam logic [G_ADDR_WIDTH-1:0] LAST_A  = G_ADDR_WIDTH'(G_NUM_TAPS_A - 1);
  localparam logic [G_ADDR_WIDTH-1:0] LAST_AB = G_ADDR_WIDTH'(G_NUM_TAPS_A + G_NUM_TAPS_B - 1);

  logic [G_TAP_WIDTH-1:0]  mem [0:(1 << G_ADDR_WIDTH) - 1];
  logic [G_TAP_WIDTH-1:0]  rd_data;
  logic [G_ADDR_WIDTH-1:0] addr_cnt;
  state_t                  state, state_n;
  logic                    reload_pending;
  logic                    busy_st;
  logic                    loading;
  logic                    loading_n;
  logic                    wr_ok;

  assign busy_st   = (state == CLEAR) || (state == LOAD_A) || (state == LOAD_B) || (state == DRAIN);
  assign loading   = (state == LOAD_A) || (state == LOAD_B);
  assign loading_n = (state_n == LOAD_A) || (state_n == LOAD_B);
  assign wr_ok     = (state == DISABLED) || (state == RUN);

  always_comb begin
    state_n = state;
    case (state)
      DISABLED: if (enable) state_n = LOAD_A;
      CLEAR:    state_n = LOAD_A;
      LOAD_A:   if (addr_cnt == LAST_A) state_n = LOAD_B;
      LOAD_B:   if (addr_cnt == LAST_AB) state_n = DRAIN;
      // A reload arriving in the DRAIN cycle itself is honoured like a pending one.
      DRAIN:    state_n = (reload_pending || reload) ? CLEAR : RUN;
      RUN:      if (reload) state_n = CLEAR;
      default:  state_n = DISABLED;
    endcase
    if (!enable) state_n = DISABLED;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= DISABLED;
      addr_cnt        <= '0;
      reload_pending  <= 1'b0;
      fir_enable      <= 1'b0;
      tap_a_din_valid <= 1'b0;
      tap_b_din_valid <= 1'b0;
      load_done       <= 1'b0;
      cfg_wr_err      <= 1'b0;
    end else begin
      state           <= state_n;
      // Counter restarts whenever a load is entered from outside the load states.
      addr_cnt        <= (loading && loading_n) ? addr_cnt + 1'b1 : '0;
      if (!enable || state == DRAIN)
        reload_pending <= 1'b0;
      else if (reload && busy_st)
        reload_pending <= 1'b1;
      fir_enable      <= (state_n == LOAD_A) || (state_n == LOAD_B) ||
                         (state_n == DRAIN)  || (state_n == RUN);
      tap_a_din_valid <= enable && (state == LOAD_A);
      tap_b_din_valid <= enable && (state == LOAD_B);
      load_done       <= (state_n == RUN) && (state != RUN);
      cfg_wr_err      <= cfg_wr_en && busy_st;
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_wr_en && wr_ok)
      mem[cfg_wr_addr] <= cfg_wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset)
      rd_data <= '0;
    else if (loading)
      rd_data <= mem[addr_cnt];
  end

  assign tap_a_din  = rd_data;
  assign tap_b_din  = rd_data;
  assign busy       = busy_st;

  assign dout       = din;
  assign dout_valid = (state == RUN) && din_valid;
  assign din_ready  = (state == RUN) && dout_ready;

endmodule

// File: tb/tb_fir_tap_load_sequencer.sv
// Scoreboard bench for fir_tap_load_sequencer: expected tap streams and samples are queued
// from a reference coefficient array; a negedge monitor pops and compares DUT output.
`timescale 1ns/1ps
module tb_fir_tap_load_sequencer;

  localparam int NA = 63;
  localparam int NB = 31;
  localparam int NT = NA + NB;

  logic        clk = 1'b0;
  logic        reset, enable, reload, cfg_wr_en;
  logic [6:0]  cfg_wr_addr;
  logic [15:0] cfg_wr_data;
  logic        cfg_wr_err, fir_enable, busy, load_done;
  logic [15:0] tap_a_din, tap_b_din;
  logic        tap_a_din_valid, tap_b_din_valid;
  logic [23:0] din, dout;
  logic        din_valid, din_ready, dout_valid, dout_ready;

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] ref_mem [0:127];
  logic [16:0] tap_q [$];
  logic [23:0] s_q [$];
  bit          smon = 1'b0;

  fir_tap_load_sequencer #(
    .G_DWIDTH(24), .G_TAP_WIDTH(16), .G_NUM_TAPS_A(NA), .G_NUM_TAPS_B(NB), .G_ADDR_WIDTH(7)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .reload(reload),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .cfg_wr_err(cfg_wr_err), .fir_enable(fir_enable),
    .tap_a_din(tap_a_din), .tap_a_din_valid(tap_a_din_valid),
    .tap_b_din(tap_b_din), .tap_b_din_valid(tap_b_din_valid),
    .busy(busy), .load_done(load_done),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected tap stream of one full load: ascending addresses, first NA to stage A.
  task automatic push_load();
    for (int i = 0; i < NT; i++)
      tap_q.push_back({(i >= NA) ? 1'b1 : 1'b0, ref_mem[i]});
  endtask

  always @(negedge clk) begin
    if (tap_a_din_valid || tap_b_din_valid) begin
      logic [16:0] e;
      chk("tap_one_valid", tap_a_din_valid && tap_b_din_valid, 0);
      chk("tap_q_nonempty", tap_q.size() != 0, 1);
      if (tap_q.size() != 0) begin
        e = tap_q.pop_front();
        chk("tap_stage", tap_b_din_valid, e[16]);
        chk("tap_data", tap_b_din_valid ? tap_b_din : tap_a_din, e[15:0]);
      end
    end
    if (smon && dout_valid && dout_ready) begin
      chk("sample_q_nonempty", s_q.size() != 0, 1);
      if (s_q.size() != 0)
        chk("sample_data", dout, s_q.pop_front());
    end
  end

  task automatic cfg_write(input logic [6:0] a, input logic [15:0] d, input bit accept);
    cfg_wr_en = 1'b1; cfg_wr_addr = a; cfg_wr_data = d;
    tick();
    cfg_wr_en = 1'b0;
    chk("cfg_wr_err", cfg_wr_err, accept ? 0 : 1);
    if (accept) ref_mem[a] = d;
  endtask

  // Caller has set the cycle-0 stimulus (enable rising or reload pulse) at posedge+1.
  task automatic load_timeline(input bit is_reload, input int n_loads, input int wr_c, input int rl_c);
    int la0;
    int run_c;
    la0 = is_reload ? 2 : 1;
    run_c = la0 + (n_loads - 1) * (NT + 2) + NT + 1;
    smon = 1'b0; din_valid = 1'b1; dout_ready = 1'b1;
    for (int c = 0; c <= run_c + 1; c++) begin
      bit e_busy, e_va, e_vb, e_clr, e_run;
      e_busy = 0; e_va = 0; e_vb = 0; e_clr = 0;
      if (c > 0) begin
        reload = (c == rl_c);
        cfg_wr_en = (c == wr_c);
        cfg_wr_addr = 7'd5; cfg_wr_data = 16'h1234;
        din = 24'($urandom);
      end
      for (int k = 0; k < n_loads; k++) begin
        int o;
        o = c - (la0 + k * (NT + 2));
        if (o >= 0 && o <= NT) begin
          e_busy = 1;
          e_va = (o >= 1 && o <= NA);
          e_vb = (o > NA && o <= NT);
        end
        if (o == -1 && (k > 0 || is_reload)) begin
          e_busy = 1; e_clr = 1;
        end
      end
      e_run = (c >= run_c) || (is_reload && c == 0);
      @(negedge clk);
      chk("fir_enable", fir_enable, ((c >= la0) || (is_reload && c == 0)) && !e_clr);
      chk("busy", busy, e_busy);
      chk("tap_a_valid", tap_a_din_valid, e_va);
      chk("tap_b_valid", tap_b_din_valid, e_vb);
      chk("load_done", load_done, c == run_c);
      chk("din_ready", din_ready, e_run);
      chk("dout_valid", dout_valid, e_run);
      chk("cfg_wr_err_load", cfg_wr_err, (wr_c >= 0) && (c == wr_c + 1));
      tick();
    end
    reload = 1'b0; cfg_wr_en = 1'b0; din_valid = 1'b0;
    chk("tap_q_drained", tap_q.size(), 0);
  endtask

  initial begin
    int acc;
    bit have;
    reset = 1'b1; enable = 1'b0; reload = 1'b0; cfg_wr_en = 1'b0;
    cfg_wr_addr = '0; cfg_wr_data = '0; din = '0; din_valid = 1'b1; dout_ready = 1'b1;
    tick(); tick();
    chk("rst_fir_enable", fir_enable, 0);
    chk("rst_tap_a_valid", tap_a_din_valid, 0);
    chk("rst_tap_b_valid", tap_b_din_valid, 0);
    chk("rst_tap_data", {tap_a_din, tap_b_din}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_cfg_wr_err", cfg_wr_err, 0);
    chk("rst_din_ready", din_ready, 0);
    chk("rst_dout_valid", dout_valid, 0);
    reset = 1'b0; din_valid = 1'b0;
    tick();

    for (int i = 0; i < NT; i++) cfg_write(7'(i), 16'(i + 1), 1'b1);
    cfg_write(7'd100, 16'($urandom), 1'b1);
    cfg_write(7'd127, 16'($urandom), 1'b1);

    // Initial load from DISABLED.
    push_load();
    enable = 1'b1;
    load_timeline(1'b0, 1, -1, -1);

    // Random sample traffic through RUN.
    smon = 1'b1; acc = 0; have = 0;
    for (int cyc = 0; cyc < 3000 && acc < 100; cyc++) begin
      if (!have) begin
        if ($urandom_range(3) != 0) begin
          din = 24'($urandom); din_valid = 1'b1; have = 1; s_q.push_back(din);
        end else begin
          din = 24'($urandom); din_valid = 1'b0;
        end
      end
      dout_ready = 1'($urandom_range(1));
      @(negedge clk);
      chk("run_din_ready", din_ready, dout_ready);
      chk("run_dout_valid", dout_valid, din_valid);
      if (din_valid && din_ready) begin have = 0; acc++; end
      tick();
    end
    din_valid = 1'b0; smon = 1'b0;
    chk("samples_accepted", acc, 100);
    chk("sample_q_drained", s_q.size(), 0);

    // Rewrite a coefficient in RUN, then reload.
    cfg_write(7'd0, 16'h7FFF, 1'b1);
    push_load();
    reload = 1'b1;
    load_timeline(1'b1, 1, -1, -1);

    // Rejected write at load cycle 10 and reload at load cycle 20 chain a second load.
    push_load(); push_load();
    reload = 1'b1;
    load_timeline(1'b1, 2, 12, 22);

    // Drop enable in LOAD_B (load offset 70), then re-enable.
    push_load();
    reload = 1'b1;
    for (int c = 0; c < 2 + 70; c++) begin
      tick();
      reload = 1'b0;
    end
    enable = 1'b0;
    tick();
    @(negedge clk);
    chk("drop_fir_enable", fir_enable, 0);
    chk("drop_busy", busy, 0);
    chk("drop_tap_valid", tap_a_din_valid || tap_b_din_valid, 0);
    tick();
    chk("drop_taps_left", tap_q.size(), NT - 70);
    tap_q.delete();
    for (int c = 0; c < 4; c++) tick();
    push_load();
    enable = 1'b1;
    load_timeline(1'b0, 1, -1, -1);

    // Synchronous reset while a sample is being offered in RUN.
    reset = 1'b1; din_valid = 1'b1; dout_ready = 1'b1;
    @(negedge clk);
    chk("pre_rst_dout_valid", dout_valid, 1);
    tick();
    @(negedge clk);
    chk("run_rst_fir_enable", fir_enable, 0);
    chk("run_rst_busy", busy, 0);
    chk("run_rst_load_done", load_done, 0);
    chk("run_rst_tap_valid", {tap_a_din_valid, tap_b_din_valid}, 0);
    chk("run_rst_tap_data", {tap_a_din, tap_b_din}, 0);
    chk("run_rst_cfg_wr_err", cfg_wr_err, 0);
    chk("run_rst_din_ready", din_ready, 0);
    chk("run_rst_dout_valid", dout_valid, 0);
    tick();
    reset = 1'b0; enable = 1'b0; din_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
